dr_adder_seq_ctrl: RTL and testbench

- Synchronous controller that runs one dual-rail (NULL/DATA, four-phase) full-adder cell bit-serially to form a WIDTH-bit ripple add.
- Per bit: issues a DATA wave (a[i], b[i], carry), waits for adder completion and captures s/c_out. Then issues a NULL wave and waits for the return to NULL.
- Sits between clocked logic (start/valid handshake) and the asynchronous adder link signals, which it synchronizes.

---
 rtl/dr_adder_seq_ctrl.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_dr_adder_seq_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dr_adder_seq_ctrl.sv
// -----------------------------------------------------------------------------
// dr_adder_seq_ctrl
//
// Clocked sequencer for a single dual-rail (NULL/DATA, four-phase) full-adder
// cell. The cell is reused bit-serially to perform a WIDTH-bit ripple add, LSB
// first. For each bit the controller issues a DATA wave, waits for completion,
// captures the sum and carry bits, then issues a NULL wave and waits for the
// cell to return to NULL.
//
// Rail encoding: NULL=2'b00, FALSE=2'b01, TRUE=2'b10. 2'b11 is illegal.
//
// Handshake (clocked side): a request is accepted on any rising clock edge
// where start & ready are both high. Operands and carry-in are sampled on that
// edge. valid pulses for one cycle when sum/cout hold the result, and ready is
// already high in that cycle, so a new start can be accepted there.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, ready      request / idle-and-can-accept
//   op_a, op_b        WIDTH-bit operands, latched on accept
//   op_cin            carry-in, latched on accept
//   sum, cout         result and carry-out, meaningful while valid=1
//   valid             one-cycle result strobe
//   err               sticky error flag, cleared on accept or rst
//   a_dr, b_dr        dual-rail operand bits to the adder cell
//   cin_dr            dual-rail carry to the adder cell
//   in_ack            async input-side completion from the cell
//   s_dr, cout_dr     async dual-rail sum / carry from the cell
//   out_rfd           ready-for-data to the cell outputs (1=DATA, 0=NULL)
//   dbg_state         current FSM state encoding
// -----------------------------------------------------------------------------
module dr_adder_seq_ctrl #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             valid,
  output logic             err,
  output logic [1:0]       a_dr,
  output logic [1:0]       b_dr,
  output logic [1:0]       cin_dr,
  input  logic             in_ack,
  input  logic [1:0]       s_dr,
  input  logic [1:0]       cout_dr,
  output logic             out_rfd,
  output logic [2:0]       dbg_state
);

  localparam int IW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  // S_DRAIN is the error-recovery wait: rails held NULL, out_rfd low, until
  // the cell has fully returned to NULL after an illegal code was seen.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DATA  = 3'd1,
    S_NULL  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t state_q, state_d;

  function automatic logic [1:0] enc(input logic b);
    return b ? 2'b10 : 2'b01;
  endfunction

  // ---------------------------------------------------------------------------
  // Input synchronizers. The rails are synchronized bit-wise; this is safe
  // because four-phase rails only move monotonically (NULL -> one rail high ->
  // NULL), so a partially-updated sample reads as "not yet complete".
  // ---------------------------------------------------------------------------
  logic [4:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= {in_ack, s_dr, cout_dr};
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  logic       ack_s;
  logic [1:0] s_s;
  logic [1:0] c_s;

  assign ack_s = sync_q[SYNC_STAGES-1][4];
  assign s_s   = sync_q[SYNC_STAGES-1][3:2];
  assign c_s   = sync_q[SYNC_STAGES-1][1:0];

  logic out_data, out_null, illegal;

  assign out_data = ((s_s == 2'b01) || (s_s == 2'b10)) &&
                    ((c_s == 2'b01) || (c_s == 2'b10));
  assign out_null = (s_s == 2'b00) && (c_s == 2'b00);
  assign illegal  = (s_s == 2'b11) || (c_s == 2'b11);

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] a_q, b_q;
  logic             carry_q;
  logic [IW-1:0]    i_q, i_inc;
  logic [CW-1:0]    cnt_q;

  logic accept, data_done, null_done, last_bit, tmo_hit;

  assign accept    = start && ready;
  assign data_done = ack_s && out_data;
  assign null_done = !ack_s && out_null;
  assign last_bit  = (i_q == IW'(WIDTH - 1));
  assign i_inc     = last_bit ? '0 : i_q + IW'(1);
  assign tmo_hit   = (TIMEOUT > 0) && (cnt_q == CW'(TO_LAST));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. Within a wait, illegal beats completion, and completion
  // beats timeout.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_DATA;
      end
      S_DATA: begin
        if (illegal)        state_d = S_DRAIN;
        else if (data_done) state_d = S_NULL;
        else if (tmo_hit)   state_d = S_IDLE;
      end
      S_NULL: begin
        if (illegal)        state_d = S_DRAIN;
        else if (null_done) state_d = last_bit ? S_DONE : S_DATA;
        else if (tmo_hit)   state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (null_done)      state_d = S_IDLE;
        else if (tmo_hit)   state_d = S_IDLE;
      end
      S_DONE: begin
        state_d = accept ? S_DATA : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. Every output is registered, so this block computes the value
  // each output takes together with the state being entered. Rails therefore
  // change only on state entry.
  // ---------------------------------------------------------------------------
  logic       a_bit, b_bit, c_bit;
  logic [1:0] a_dr_d, b_dr_d, cin_dr_d;
  logic       rfd_d, ready_d, valid_d;

  always_comb begin
    // Bit presented in the next DATA wave: bit 0 of the incoming operands on
    // accept, the next bit when leaving NULL, otherwise the current bit.
    a_bit = a_q[i_q];
    b_bit = b_q[i_q];
    c_bit = carry_q;
    if (accept) begin
      a_bit = op_a[0];
      b_bit = op_b[0];
      c_bit = op_cin;
    end else if (state_q == S_NULL) begin
      a_bit = a_q[i_inc];
      b_bit = b_q[i_inc];
    end

    a_dr_d   = 2'b00;
    b_dr_d   = 2'b00;
    cin_dr_d = 2'b00;
    if (state_d == S_DATA) begin
      a_dr_d   = enc(a_bit);
      b_dr_d   = enc(b_bit);
      cin_dr_d = enc(c_bit);
    end

    rfd_d   = !((state_d == S_NULL) || (state_d == S_DRAIN));
    ready_d = (state_d == S_IDLE) || (state_d == S_DONE);
    valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_dr    <= 2'b00;
      b_dr    <= 2'b00;
      cin_dr  <= 2'b00;
      out_rfd <= 1'b1;
      ready   <= 1'b1;
      valid   <= 1'b0;
    end else begin
      a_dr    <= a_dr_d;
      b_dr    <= b_dr_d;
      cin_dr  <= cin_dr_d;
      out_rfd <= rfd_d;
      ready   <= ready_d;
      valid   <= valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Operand, result, index and error registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      i_q     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state_q)
        S_DATA: begin
          if (illegal) begin
            err <= 1'b1;
          end else if (data_done) begin
            sum[i_q] <= s_s[1];
            carry_q  <= c_s[1];
          end else if (tmo_hit) begin
            err <= 1'b1;
          end
        end
        S_NULL: begin
          if (illegal) begin
            err <= 1'b1;
          end else if (null_done) begin
            if (last_bit) cout <= carry_q;
            else          i_q  <= i_inc;
          end else if (tmo_hit) begin
            err <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (!null_done && tmo_hit) err <= 1'b1;
        end
        default: ;
      endcase

      // accept is only possible in IDLE/DONE, so it never collides with the
      // wait-state updates above.
      if (accept) begin
        a_q     <= op_a;
        b_q     <= op_b;
        carry_q <= op_cin;
        i_q     <= '0;
        err     <= 1'b0;
      end
    end
  end

  // Per-phase wait counter: cleared on every state change, counts while in a
  // wait state, saturates so it never wraps back below the timeout value.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_d != state_q) begin
      cnt_q <= '0;
    end else if (((state_q == S_DATA) || (state_q == S_NULL) ||
                  (state_q == S_DRAIN)) && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_dr_adder_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dr_adder_seq_ctrl
//
// Directed bench for dr_adder_seq_ctrl (WIDTH=8, SYNC_STAGES=2, TIMEOUT=16).
// A behavioural dual-rail full-adder with a 3-cycle delay answers the rails.
// Expected sums are hand-computed constants pushed into exp_q when a request
// is issued; a monitor pops and compares on every valid pulse.
// -----------------------------------------------------------------------------
module tb_dr_adder_seq_ctrl;

  localparam int W = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT signals
  logic         start  = 1'b0;
  logic [W-1:0] op_a   = '0;
  logic [W-1:0] op_b   = '0;
  logic         op_cin = 1'b0;
  logic         ready, valid, err, cout, out_rfd;
  logic [W-1:0] sum;
  logic [1:0]   a_dr, b_dr, cin_dr;
  logic         in_ack  = 1'b0;
  logic [1:0]   s_dr    = 2'b00;
  logic [1:0]   cout_dr = 2'b00;
  logic [2:0]   dbg_state;

  dr_adder_seq_ctrl #(.WIDTH(W), .SYNC_STAGES(2), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready),
    .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
    .sum(sum), .cout(cout), .valid(valid), .err(err),
    .a_dr(a_dr), .b_dr(b_dr), .cin_dr(cin_dr),
    .in_ack(in_ack), .s_dr(s_dr), .cout_dr(cout_dr),
    .out_rfd(out_rfd), .dbg_state(dbg_state)
  );

  // bookkeeping
  int checks = 0;
  int errors = 0;
  logic [W:0] exp_q[$];   // {cout, sum}
  int pushed    = 0;
  int valid_cnt = 0;
  int waves     = 0;
  logic [1:0] a_prev = 2'b00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural dual-rail full adder, 3-cycle delay per phase.
  // stuck: never acknowledge. bad_wave: DATA wave index answered with s=11.
  // ---------------------------------------------------------------------------
  bit stuck    = 1'b0;
  int bad_wave = -1;
  int m_cnt    = 0;
  int m_wave   = 0;

  function automatic logic isd(input logic [1:0] r);
    return (r == 2'b01) || (r == 2'b10);
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      in_ack  = 1'b0;
      s_dr    = 2'b00;
      cout_dr = 2'b00;
      m_cnt   = 0;
      m_wave  = 0;
    end else begin
      if (ready) m_wave = 0;
      if (!in_ack) begin
        if (!stuck && isd(a_dr) && isd(b_dr) && isd(cin_dr) && out_rfd) begin
          m_cnt++;
          if (m_cnt == 3) begin
            logic x, y, z;
            x = a_dr[1]; y = b_dr[1]; z = cin_dr[1];
            s_dr    = (x ^ y ^ z) ? 2'b10 : 2'b01;
            cout_dr = ((x & y) | (x & z) | (y & z)) ? 2'b10 : 2'b01;
            if (m_wave == bad_wave) s_dr = 2'b11;
            in_ack = 1'b1;
            m_cnt  = 0;
            m_wave++;
          end
        end else begin
          m_cnt = 0;
        end
      end else begin
        if (a_dr == 2'b00 && b_dr == 2'b00 && cin_dr == 2'b00 && !out_rfd) begin
          m_cnt++;
          if (m_cnt == 3) begin
            in_ack  = 1'b0;
            s_dr    = 2'b00;
            cout_dr = 2'b00;
            m_cnt   = 0;
          end
        end else begin
          m_cnt = 0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (rst) begin
      waves  = 0;
      a_prev = 2'b00;
    end else begin
      if (valid) begin
        valid_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid actual=valid sum=%0h expected=no valid", sum);
        end else begin
          logic [W:0] e;
          e = exp_q.pop_front();
          chk("sum", {24'd0, sum}, {24'd0, e[W-1:0]});
          chk("cout", {31'd0, cout}, {31'd0, e[W]});
          chk("err_at_valid", {31'd0, err}, 32'd0);
          chk("data_waves", waves, W);
        end
        waves = 0;
      end else if (ready) begin
        waves = 0;
      end
      if (a_prev == 2'b00 && a_dr != 2'b00) waves++;
      a_prev = a_dr;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      checks++;
      errors++;
      $display("FAIL %s_ready_timeout actual=ready0 expected=ready1", name);
    end
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    wait_ready("issue");
    op_a = a; op_b = b; op_cin = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valids(input string name);
    int n;
    n = 0;
    while (valid_cnt < pushed && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (valid_cnt < pushed) begin
      checks++;
      errors++;
      $display("FAIL %s_valid_timeout actual=%0d expected=%0d", name, valid_cnt, pushed);
    end
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic [W-1:0] es, input logic ec);
    exp_q.push_back({ec, es});
    pushed++;
    issue(a, b, c);
    wait_valids(name);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int vc, t_data, t_err, n;

    // reset values
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_sum", {24'd0, sum}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    chk("rst_rails", {26'd0, a_dr, b_dr, cin_dr}, 32'd0);
    chk("rst_rfd", {31'd0, out_rfd}, 32'd1);
    chk("rst_state", {29'd0, dbg_state}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // basic add
    run_op("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);

    // back-to-back with start held high through a busy period
    exp_q.push_back({1'b1, 8'h00}); pushed++;
    exp_q.push_back({1'b1, 8'h00}); pushed++;
    wait_ready("b2b");
    op_a = 8'hFF; op_b = 8'h01; op_cin = 1'b0; start = 1'b1;
    @(negedge clk);
    op_a = 8'hFF; op_b = 8'h00; op_cin = 1'b1;
    n = 0;
    while (!valid && n < 3000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("b2b_accept_ready", {31'd0, ready}, 32'd0);
    chk("b2b_first_rail", {30'd0, a_dr}, 32'd2);
    start = 1'b0;
    wait_valids("b2b");

    // more carry patterns
    run_op("add_80_80_c1", 8'h80, 8'h80, 1'b1, 8'h01, 1'b1);
    run_op("add_00_00", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    run_op("add_aa_55_c1", 8'hAA, 8'h55, 1'b1, 8'h00, 1'b1);
    chk("one_valid_per_op", valid_cnt, pushed);

    // timeout: adder never acknowledges
    stuck = 1'b1;
    vc = valid_cnt;
    wait_ready("tmo");
    op_a = 8'h5A; op_b = 8'h3C; op_cin = 1'b0; start = 1'b1;
    t_data = -1;
    t_err  = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (t_data < 0 && a_dr != 2'b00) t_data = k;
      if (err) begin
        t_err = k;
        break;
      end
    end
    chk("tmo_delay", t_err - t_data, 16);
    chk("tmo_rails", {26'd0, a_dr, b_dr, cin_dr}, 32'd0);
    chk("tmo_rfd", {31'd0, out_rfd}, 32'd1);
    chk("tmo_ready", {31'd0, ready}, 32'd1);
    chk("tmo_no_valid", valid_cnt, vc);
    stuck = 1'b0;
    repeat (4) @(negedge clk);

    // illegal code on bit 2
    bad_wave = 2;
    vc = valid_cnt;
    issue(8'h5A, 8'h3C, 1'b0);
    n = 0;
    while (!err && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("ill_err_set", {31'd0, err}, 32'd1);
    chk("ill_rails_null", {26'd0, a_dr, b_dr, cin_dr}, 32'd0);
    chk("ill_rfd_low", {31'd0, out_rfd}, 32'd0);
    wait_ready("ill");
    chk("ill_rfd_restored", {31'd0, out_rfd}, 32'd1);
    chk("ill_err_sticky", {31'd0, err}, 32'd1);
    chk("ill_no_valid", valid_cnt, vc);
    bad_wave = -1;
    exp_q.push_back({1'b0, 8'h46}); pushed++;
    issue(8'h12, 8'h34, 1'b0);
    chk("ill_err_cleared", {31'd0, err}, 32'd0);
    wait_valids("after_ill");

    // reset during bit 3 DATA
    vc = valid_cnt;
    issue(8'hFF, 8'hFF, 1'b0);
    n = 0;
    while (waves < 4 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_reached_bit3", waves, 4);
    rst = 1'b1;
    @(negedge clk);
    chk("rstm_rails", {26'd0, a_dr, b_dr, cin_dr}, 32'd0);
    chk("rstm_rfd", {31'd0, out_rfd}, 32'd1);
    chk("rstm_ready", {31'd0, ready}, 32'd1);
    chk("rstm_valid", {31'd0, valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rstm_no_valid", valid_cnt, vc);
    run_op("add_01_01", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);

    // drain and report
    repeat (20) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    chk("valid_total", valid_cnt, pushed);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
